// File: rtl/time_display_scan_pkg.sv
// Shared constants for the six-digit multiplexed time display: glyphs,
// blink field encodings and the BCD split helper.
package time_display_scan_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_SEC  = 2'd1,
    SEL_MIN  = 2'd2,
    SEL_HR   = 2'd3
  } blink_sel_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // Active-low {g,f,e,d,c,b,a}; codes 10..15 are blank.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  // v*13 >> 7 equals v/10 exactly for every 6-bit v.
  function automatic bcd_t bcd_split(input logic [5:0] v);
    logic [5:0] t6;
    bcd_t r;
    r.tens = 4'((11'(v) * 11'd13) >> 7);
    t6     = {2'b00, r.tens};
    r.ones = 4'(v - (t6 << 3) - (t6 << 1));
    return r;
  endfunction

endpackage

// File: rtl/time_display_scan_seg7_decoder.sv
// Combinational 7-segment decoder, active-low; dash overrides the digit.
module seg7_decoder
  import time_display_scan_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dash,
  output logic [6:0] seg
);

  assign seg = dash ? SEG_DASH : glyph(digit);

endmodule

// File: rtl/time_display_scan.sv
// Six-digit multiplexed hh:mm:ss scanner with per-frame input snapshot.
// Field blinking is built only when TIME_DISPLAY_BLINK_EN is defined.
module time_display_scan
  import time_display_scan_pkg::*;
#(
  parameter int P_SCAN_DIV     = 50000,
  parameter int P_BLINK_FRAMES = 64
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hr,
  input  logic [1:0] i_blink_sel,
  output logic [5:0] o_an,
  output logic [6:0] o_seg,
  output logic       o_dp
);

  localparam int DW = (P_SCAN_DIV > 1) ? $clog2(P_SCAN_DIV) : 1;

  logic [DW-1:0] div_q;
  logic [2:0]    idx_q;
  logic          run_q;
  logic [5:0]    sec_q, min_q;
  logic [4:0]    hr_q;
  logic          tick, wrap, blank_field;

  assign tick = (div_q == DW'(P_SCAN_DIV - 1));
  assign wrap = tick && (idx_q == 3'(NUM_DIGITS - 1));

  // run_q keeps the display dark until the first snapshot has been taken.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      div_q <= '0;
      idx_q <= 3'(NUM_DIGITS - 1);
      run_q <= 1'b0;
      sec_q <= '0;
      min_q <= '0;
      hr_q  <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) idx_q <= wrap ? 3'd0 : idx_q + 3'd1;
      if (wrap) begin
        run_q <= 1'b1;
        sec_q <= i_sec;
        min_q <= i_min;
        hr_q  <= i_hr;
      end
    end
  end

  logic [1:0] field;
  assign field = idx_q[2:1];

`ifdef TIME_DISPLAY_BLINK_EN
  localparam int BW = (P_BLINK_FRAMES > 1) ? $clog2(P_BLINK_FRAMES) : 1;
  blink_sel_e  sel_q;
  logic [BW-1:0] bcnt_q;
  logic        phase_q;

  // Frames are counted as they complete, so the very first wrap does not count.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      sel_q   <= SEL_NONE;
      bcnt_q  <= '0;
      phase_q <= 1'b1;
    end else if (wrap) begin
      sel_q <= blink_sel_e'(i_blink_sel);
      if (run_q) begin
        if (bcnt_q == BW'(P_BLINK_FRAMES - 1)) begin
          bcnt_q  <= '0;
          phase_q <= ~phase_q;
        end else begin
          bcnt_q <= bcnt_q + 1'b1;
        end
      end
    end
  end

  assign blank_field = !phase_q && (sel_q != SEL_NONE) &&
                       (sel_q == blink_sel_e'(field + 2'd1));
`else
  logic unused_blink_sel;
  assign unused_blink_sel = &{1'b0, i_blink_sel};
  assign blank_field      = 1'b0;
`endif

  logic [5:0] fval;
  logic       over;
  bcd_t       bcd;
  logic [3:0] digit;
  logic [6:0] seg_d;
  logic [5:0] an_d;

  always_comb begin
    fval = '0;
    over = 1'b0;
    case (field)
      2'd0:    begin fval = sec_q;          over = (sec_q > 6'd59); end
      2'd1:    begin fval = min_q;          over = (min_q > 6'd59); end
      default: begin fval = {1'b0, hr_q};   over = (hr_q  > 5'd23); end
    endcase
  end

  assign bcd   = bcd_split(fval);
  assign digit = idx_q[0] ? bcd.tens : bcd.ones;

  seg7_decoder u_dec (
    .digit (digit),
    .dash  (over),
    .seg   (seg_d)
  );

  always_comb begin
    an_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx_q == 3'(i) && !blank_field) an_d[i] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn || !run_q) begin
      o_an  <= '1;
      o_seg <= SEG_BLANK;
      o_dp  <= 1'b1;
    end else begin
      o_an  <= an_d;
      o_seg <= seg_d;
      o_dp  <= !(idx_q == 3'd2 || idx_q == 3'd4);
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// Randomized bench for time_display_scan against a cycle-count reference model.
module tb_time_display_scan;

  localparam int P  = 4;
  localparam int PB = 2;
`ifdef TIME_DISPLAY_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic [5:0] i_sec = '0, i_min = '0;
  logic [4:0] i_hr = '0;
  logic [1:0] i_blink_sel = '0;
  logic [5:0] o_an;
  logic [6:0] o_seg;
  logic       o_dp;

  int checks = 0, failures = 0;
  int n = 0, cur_d = -1, cur_f = 0;
  int s_sec[1024], s_min[1024], s_hr[1024], s_sel[1024];
  logic [6:0] glyph_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

  time_display_scan #(.P_SCAN_DIV(P), .P_BLINK_FRAMES(PB)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_sec       (i_sec),
    .i_min       (i_min),
    .i_hr        (i_hr),
    .i_blink_sel (i_blink_sel),
    .o_an        (o_an),
    .o_seg       (o_seg),
    .o_dp        (o_dp)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  // Model: n = edges since reset release. Tick m lands on edge m*P, shows
  // digit (m-1)%6 of frame (m-1)/6+1 one edge later.
  task automatic step(input string ctx);
    bit r, blank;
    int m, d, f, fld, v, lim, dig;
    logic [5:0] ea;
    @(posedge i_clk);
    r = !i_rstn;
    if (r) n = 0;
    else begin
      n++;
      if (n % P == 0 && ((n / P - 1) % 6) == 0) begin
        f = (n / P - 1) / 6 + 1;
        s_sec[f] = i_sec; s_min[f] = i_min; s_hr[f] = i_hr; s_sel[f] = i_blink_sel;
      end
    end
    #1;
    if (r || n - 1 < P) begin
      cur_d = -1; cur_f = 0;
      chk({ctx, "_an_idle"}, 32'(o_an), 32'h3f);
      chk({ctx, "_seg_idle"}, 32'(o_seg), 32'h7f);
      chk({ctx, "_dp_idle"}, 32'(o_dp), 32'h1);
    end else begin
      m = (n - 1) / P;
      d = (m - 1) % 6;
      f = (m - 1) / 6 + 1;
      cur_d = d; cur_f = f;
      fld = d / 2;
      v   = (fld == 0) ? s_sec[f] : (fld == 1) ? s_min[f] : s_hr[f];
      lim = (fld == 2) ? 23 : 59;
      dig = (d % 2) ? v / 10 : v % 10;
      blank = BLINK_EN && (((f - 1) / PB) % 2 == 1) && (s_sel[f] == fld + 1);
      ea = blank ? 6'h3f : ~(6'd1 << d);
      chk({ctx, "_an"}, 32'(o_an), 32'(ea));
      if (!blank) chk({ctx, "_seg"}, 32'(o_seg), (v > lim) ? 32'h3f : 32'(glyph_tbl[dig]));
      chk({ctx, "_dp"}, 32'(o_dp), (d == 2 || d == 4) ? 32'h0 : 32'h1);
    end
  endtask

  task automatic run(input int cycles, input string ctx);
    for (int i = 0; i < cycles; i++) step(ctx);
  endtask

  task automatic wait_digit(input int d, input string ctx);
    int k;
    k = 0;
    while (cur_d != d && k < 200) begin step(ctx); k++; end
    chk({ctx, "_timeout"}, 32'(cur_d == d), 32'h1);
  endtask

  initial begin
    i_rstn = 1'b0;
    run(3, "rst");

    // First digit timing after release
    i_sec = 6'd7; i_min = '0; i_hr = '0; i_blink_sel = '0;
    i_rstn = 1'b1;
    run(P, "pre");
    step("first");
    chk("first_an", 32'(o_an), 32'h3e);
    chk("first_seg", 32'(o_seg), 32'h78);

    // 12:34:56 scan order
    i_hr = 5'd12; i_min = 6'd34; i_sec = 6'd56;
    run(3 * 6 * P, "scan");

    // Coherency: seconds change while digit 3 is lit
    i_sec = 6'd59;
    wait_digit(0, "coh_w0");
    wait_digit(3, "coh_w3");
    i_sec = 6'd0;
    run(2 * 6 * P, "coh");

    // Out-of-range fields
    i_sec = 6'd60; i_min = 6'd37; i_hr = 5'd24;
    run(2 * 6 * P, "rng");

    // Blink on minutes from a fresh reset
    i_rstn = 1'b0;
    run(2, "brst");
    i_sec = 6'd56; i_min = 6'd34; i_hr = 5'd12; i_blink_sel = 2'd2;
    i_rstn = 1'b1;
    run(P + 7 * 6 * P, "blink");

    // Reset while on digit 4, then restart timing
    wait_digit(4, "mrst_w");
    i_rstn = 1'b0;
    step("mrst");
    i_rstn = 1'b1;
    i_blink_sel = 2'd0;
    run(P + 1 + 2 * 6 * P, "restart");

    // Random inputs with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) i_sec = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) i_min = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) i_hr  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) i_blink_sel = 2'($urandom_range(0, 3));
      i_rstn = !($urandom_range(0, 299) == 0 || cur_f > 900);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_display_scan.md
TIME_DISPLAY_SCAN -- requirements
Module: time_display_scan

Interface
REQ-001 The block SHALL have parameter P_SCAN_DIV, default 50000: clock cycles per digit slot (must be at least 2).
REQ-002 The block SHALL have parameter P_BLINK_FRAMES, default 64: full 6-digit frames per blink phase.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single system clock, rising edge.
REQ-004 The block SHALL have port i_rstn, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port i_sec, input, 6 bits: binary seconds from the stopwatch counters.
REQ-006 The block SHALL have port i_min, input, 6 bits: binary minutes.
REQ-007 The block SHALL have port i_hr, input, 5 bits: binary hours.
REQ-008 The block SHALL have port i_blink_sel, input, 2 bits: field under edit (0 none, 1 sec, 2 min, 3 hr).
REQ-009 The block SHALL have port o_an, output, 6 bits: digit enables, active-low, at most one low.
REQ-010 The block SHALL have port o_seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-011 The block SHALL have port o_dp, output, 1 bit: decimal point, active-low.

Function
REQ-012 The divider SHALL count 0..P_SCAN_DIV-1 and wrap; scan tick = divider at P_SCAN_DIV-1.
REQ-013 On each scan tick, digit index SHALL advance 0->1->...->5->0 (wrap 5->0).
REQ-014 Digit map SHALL be: 0 sec ones, 1 sec tens, 2 min ones, 3 min tens, 4 hr ones, 5 hr tens.
REQ-015 Frame snapshot SHALL capture i_sec, i_min, i_hr and i_blink_sel on the tick where the index wraps to 0.
REQ-016 All six digits of one frame SHALL come from the same snapshot; input changes mid-frame SHALL NOT appear until the next frame.
REQ-017 o_an, o_seg and o_dp SHALL be registered and SHALL update on the edge after an index change (1-cycle latency).
REQ-018 Tens and ones SHALL be value/10 and value%10, computed without a divider primitive.
REQ-019 Sec or min above 59, or hr above 23, SHALL drive both digits of that field as '-' (o_seg = 7'b0111111).
REQ-020 Digit glyphs SHALL be 0..9 standard; '0' = 7'b1000000, '8' = 7'b0000000.
REQ-021 o_dp SHALL be low on digits 2 and 4 (field separators) and high otherwise.
REQ-022 The blink phase SHALL toggle after every P_BLINK_FRAMES frame wraps.
REQ-023 While the blink phase is 0 and the snapshotted i_blink_sel selects a field, both digits of that field SHALL have o_an high; o_seg is don't-care.
REQ-024 i_blink_sel = 0 SHALL never suppress any digit.

Reset
REQ-025 While i_rstn is low at an edge: divider 0, index 5, snapshot 0, blink counter 0, blink phase 1, o_an 6'b111111, o_seg 7'b1111111, o_dp 1.
REQ-026 Reset asserted mid-frame SHALL take effect at the next edge and discard the partial frame.
REQ-027 The first scan tick after reset SHALL wrap the index to 0 and load the snapshot.

Configuration
REQ-028 With macro TIME_DISPLAY_BLINK_EN defined, blink per REQ-022..024 SHALL be built.
REQ-029 Without TIME_DISPLAY_BLINK_EN, the blink counter and phase SHALL be absent, i_blink_sel SHALL be ignored, and all digits SHALL always be driven.

Structure
REQ-030 The shared package SHALL hold the digit count (6), the segment glyph constants including dash and blank, and the blink_sel field encodings.
REQ-031 The block SHALL contain one sub-module, seg7_decoder (4-bit digit plus dash flag in, 7-bit active-low segments out, combinational).

Verification
REQ-032 Reset, P_SCAN_DIV=4, inputs sec=7, min=0, hr=0, blink_sel=0: o_an=6'b111110 and o_seg=7'b1111000 ('7') appear exactly P_SCAN_DIV+1 edges after release, with o_an=6'b111111 before that.
REQ-033 Scan order and wrap: hold 12:34:56 -> digits 0..5 show 6,5,4,3,2,1; o_dp low on digits 2 and 4 only; o_an returns to 6'b111110 after slot 5.
REQ-034 Coherency: change sec 59->0 while digit 3 is active -> digits 0/1 of the current frame still show 9/5, and 0/0 appear next frame.
REQ-035 Range: sec=60, hr=24 -> digits 0,1,4,5 show 7'b0111111; minutes decode normally.
REQ-036 Blink, macro defined, P_BLINK_FRAMES=2, blink_sel=2: o_an bits 2 and 3 stay high for frames 3-4, are driven in frames 1-2 and 5-6, and other digits are unaffected; with the macro undefined, bits 2 and 3 are driven in every frame.
REQ-037 Mid-frame reset: assert i_rstn low while on digit 4 -> next edge shows o_an=6'b111111, and the restart follows REQ-032 timing.
